// File: rtl/wb_i2c_seq.sv
// Wishbone master that sequences one I2C register write or read
// through an i2c core: prescale/enable setup, TXR/CR writes, SR polling.
module wb_i2c_seq #(
  parameter logic [31:0] I2C_BASE = 32'h6000_0000,
  parameter logic [15:0] PRESCALE = 16'd99,
  parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic        cmd_rd,
  input  logic [6:0]  cmd_dev,
  input  logic [7:0]  cmd_reg,
  input  logic [7:0]  cmd_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic        m_ack_i
);

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] INIT       = 4'd1;
  localparam logic [3:0] LD_TXR     = 4'd2;
  localparam logic [3:0] WR_CR      = 4'd3;
  localparam logic [3:0] POLL       = 4'd4;
  localparam logic [3:0] CHK        = 4'd5;
  localparam logic [3:0] ABORT_STO  = 4'd6;
  localparam logic [3:0] ABORT_POLL = 4'd7;
  localparam logic [3:0] RD_RXR     = 4'd8;
  localparam logic [3:0] FIN        = 4'd9;

  logic [3:0]  state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic        init_q, init_d;
  logic        rd_q, rd_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wd_q, wd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  sr_q, sr_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [7:0]  dat_q, dat_d;

  logic        ack;
  logic        req;
  logic        req_we;
  logic [2:0]  req_off;
  logic [7:0]  req_byte;
  logic        rd_ph;
  logic        last_ph;
  logic [7:0]  txr_b;
  logic [7:0]  cr_b;
  logic        unused_hi;

  assign unused_hi = ^m_dat_i[31:8];
  assign ack = cyc_q & m_ack_i;
  assign rd_ph = rd_q && (step_q == 2'd3);
  assign last_ph = rd_q ? rd_ph : (step_q == 2'd2);

  always_comb begin
    unique case (step_q)
      2'd0:    txr_b = {dev_q, 1'b0};
      2'd1:    txr_b = reg_q;
      default: txr_b = rd_q ? {dev_q, 1'b1} : wd_q;
    endcase
    unique case (step_q)
      2'd0:    cr_b = 8'h90;
      2'd1:    cr_b = 8'h10;
      2'd2:    cr_b = rd_q ? 8'h90 : 8'h50;
      default: cr_b = 8'h68;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    init_d   = init_q;
    rd_d     = rd_q;
    dev_d    = dev_q;
    reg_d    = reg_q;
    wd_d     = wd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    sr_d     = sr_q;
    pcnt_d   = pcnt_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    req      = 1'b0;
    req_we   = 1'b0;
    req_off  = 3'd0;
    req_byte = 8'h00;
    unique case (state_q)
      IDLE: if (cmd_start) begin
        rd_d    = cmd_rd;
        dev_d   = cmd_dev;
        reg_d   = cmd_reg;
        wd_d    = cmd_wdata;
        busy_d  = 1'b1;
        err_d   = 1'b0;
        step_d  = 2'd0;
        state_d = init_q ? LD_TXR : INIT;
      end
      INIT: begin
        req     = 1'b1;
        req_we  = 1'b1;
        req_off = {1'b0, step_q};
        unique case (step_q)
          2'd0:    req_byte = PRESCALE[7:0];
          2'd1:    req_byte = PRESCALE[15:8];
          default: req_byte = 8'h80;
        endcase
        if (ack) begin
          if (step_q == 2'd2) begin
            init_d  = 1'b1;
            step_d  = 2'd0;
            state_d = LD_TXR;
          end else begin
            step_d = step_q + 2'd1;
          end
        end
      end
      LD_TXR: begin
        // the final read phase is a bare RD command, no TXR load
        if (rd_ph) begin
          state_d = WR_CR;
        end else begin
          req      = 1'b1;
          req_we   = 1'b1;
          req_off  = 3'd3;
          req_byte = txr_b;
          if (ack) state_d = WR_CR;
        end
      end
      WR_CR: begin
        req      = 1'b1;
        req_we   = 1'b1;
        req_off  = 3'd4;
        req_byte = cr_b;
        if (ack) begin
          pcnt_d  = 16'd0;
          state_d = POLL;
        end
      end
      POLL: begin
        req     = 1'b1;
        req_off = 3'd4;
        if (ack) begin
          sr_d    = m_dat_i[7:0];
          pcnt_d  = pcnt_q + 16'd1;
          state_d = CHK;
        end
      end
      CHK: begin
        if (sr_q[1]) begin
          if (pcnt_q == POLL_MAX) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            state_d = POLL;
          end
        end else if (sr_q[5]) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else if (sr_q[7] && !rd_ph) begin
          err_d   = 1'b1;
          state_d = ABORT_STO;
        end else if (last_ph) begin
          state_d = rd_q ? RD_RXR : FIN;
        end else begin
          step_d  = step_q + 2'd1;
          state_d = LD_TXR;
        end
      end
      ABORT_STO: begin
        req      = 1'b1;
        req_we   = 1'b1;
        req_off  = 3'd4;
        req_byte = 8'h40;
        if (ack) begin
          pcnt_d  = 16'd0;
          state_d = ABORT_POLL;
        end
      end
      ABORT_POLL: begin
        req     = 1'b1;
        req_off = 3'd4;
        if (ack) begin
          pcnt_d = pcnt_q + 16'd1;
          if (!m_dat_i[1] || (pcnt_d == POLL_MAX)) state_d = FIN;
        end
      end
      RD_RXR: begin
        req     = 1'b1;
        req_off = 3'd3;
        if (ack) begin
          rdata_d = m_dat_i[7:0];
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (req && !cyc_q) begin
      cyc_d = 1'b1;
      we_d  = req_we;
      adr_d = I2C_BASE + {29'd0, req_off};
      dat_d = req_byte;
    end
    if (ack) cyc_d = 1'b0;
    // done/busy are registered so they line up with the FIN cycle
    if (state_d == FIN && state_q != FIN) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      init_q  <= 1'b0;
      rd_q    <= 1'b0;
      dev_q   <= 7'd0;
      reg_q   <= 8'd0;
      wd_q    <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 8'd0;
      sr_q    <= 8'd0;
      pcnt_q  <= 16'd0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 32'd0;
      dat_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      init_q  <= init_d;
      rd_q    <= rd_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      sr_q    <= sr_d;
      pcnt_q  <= pcnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign m_adr_o = adr_q;
  assign m_dat_o = {24'd0, dat_q};
  assign m_sel_o = 4'hF;
  assign m_we_o  = we_q;
  assign m_cyc_o = cyc_q;
  assign m_stb_o = cyc_q;

endmodule

// File: tb/tb_wb_i2c_seq.sv
// Bench for wb_i2c_seq: behavioural i2c core + slave at 0x50 on the
// Wishbone side, directed register transfers and error scenarios.
module tb_wb_i2c_seq;

  localparam logic [31:0] BASE = 32'h6000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_start = 1'b0;
  logic        cmd_rd = 1'b0;
  logic [6:0]  cmd_dev = 7'd0;
  logic [7:0]  cmd_reg = 8'd0;
  logic [7:0]  cmd_wdata = 8'd0;
  logic        busy, done, err;
  logic [7:0]  rdata;
  logic [31:0] m_adr_o, m_dat_o;
  logic [31:0] m_dat_i = 32'd0;
  logic [3:0]  m_sel_o;
  logic        m_we_o, m_cyc_o, m_stb_o;
  logic        m_ack_i = 1'b0;

  int checks = 0;
  int failures = 0;

  int lat = 0;
  int stall_at = -1;
  bit force_al = 1'b0;
  bit stuck_tip = 1'b0;

  logic [7:0]  mem [256];
  logic [7:0]  txr, rxr, cr, ptr;
  bit          acked, rd_mode, is_addr, rxack;
  int          tip_left, wcnt, nbytes;
  int          sr_reads = 0, rx_reads = 0, bad_bus = 0, done_cnt = 0;
  logic [31:0] wadr [$];
  logic [31:0] wdat [$];

  wb_i2c_seq #(
    .I2C_BASE(BASE),
    .PRESCALE(16'd99),
    .POLL_MAX(16'd4)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_start(cmd_start), .cmd_rd(cmd_rd),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_sel_o(m_sel_o), .m_we_o(m_we_o), .m_cyc_o(m_cyc_o),
    .m_stb_o(m_stb_o), .m_ack_i(m_ack_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  always @(posedge clk) begin
    m_ack_i <= 1'b0;
    if (m_stb_o !== m_cyc_o || m_sel_o !== 4'hF) bad_bus++;
    if (m_cyc_o !== 1'b1) begin
      wcnt = 0;
    end else if (rst && !m_ack_i && !(m_we_o && wadr.size() == stall_at)) begin
      if (wcnt < lat) begin
        wcnt++;
      end else begin
        wcnt = 0;
        m_ack_i <= 1'b1;
        if (m_we_o) begin
          wadr.push_back(m_adr_o);
          wdat.push_back(m_dat_o);
          if (m_adr_o == BASE + 3) txr = m_dat_o[7:0];
          if (m_adr_o == BASE + 4) begin
            cr = m_dat_o[7:0];
            tip_left = 2;
            if (cr[7]) is_addr = 1'b1;
            if (cr[4]) begin
              if (is_addr) begin
                acked = (txr[7:1] == 7'h50);
                rd_mode = txr[0];
                is_addr = 1'b0;
                nbytes = 0;
              end else if (acked && !rd_mode) begin
                if (nbytes == 0) ptr = txr;
                else mem[ptr] = txr;
                nbytes++;
              end
              rxack = !acked;
            end
            if (cr[5]) begin
              rxr = mem[ptr];
              rxack = 1'b1;
            end
          end
        end else if (m_adr_o == BASE + 4) begin
          sr_reads++;
          if (stuck_tip) begin
            m_dat_i <= 32'h02;
          end else if (tip_left > 0) begin
            tip_left--;
            m_dat_i <= 32'h02;
          end else begin
            m_dat_i <= {24'd0, rxack, 1'b0, force_al, 5'd0};
          end
        end else begin
          rx_reads++;
          m_dat_i <= {24'd0, rxr};
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_cmd(input bit rd, input logic [6:0] dev,
                        input logic [7:0] rg, input logic [7:0] wd,
                        output bit ok);
    @(negedge clk);
    cmd_rd = rd;
    cmd_dev = dev;
    cmd_reg = rg;
    cmd_wdata = wd;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0 || m_we_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_bus: cyc=%b stb=%b we=%b required 0", m_cyc_o, m_stb_o, m_we_o);
    end
    checks++;
    if (m_adr_o !== 32'd0 || m_dat_o !== 32'd0) begin
      failures++;
      $display("FAIL reset_adr_dat: adr=%h dat=%h required 0", m_adr_o, m_dat_o);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || rdata !== 8'd0) begin
      failures++;
      $display("FAIL reset_status: busy=%b done=%b err=%b rdata=%h required 0", busy, done, err, rdata);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    logic [15:0] e [9] = '{16'h0063, 16'h0100, 16'h0280, 16'h03A0, 16'h0490,
                           16'h0312, 16'h0410, 16'h03A5, 16'h0450};
    int b = wadr.size();
    bit ok;
    lat = 1;
    do_cmd(1'b0, 7'h50, 8'h12, 8'hA5, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL write_done: no done within bound");
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL write_err: got %b required 0", err);
    end
    checks++;
    if (wadr.size() - b != 9) begin
      failures++;
      $display("FAIL write_count: got %0d required 9", wadr.size() - b);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (wadr.size() <= b + i || wadr[b+i] !== BASE + {24'd0, e[i][15:8]} ||
          wdat[b+i] !== {24'd0, e[i][7:0]}) begin
        failures++;
        $display("FAIL write_seq[%0d]: got adr=%h dat=%h required off=%h byte=%h",
                 i, wadr[b+i], wdat[b+i], e[i][15:8], e[i][7:0]);
      end
    end
    checks++;
    if (mem[8'h12] !== 8'hA5) begin
      failures++;
      $display("FAIL write_slave: got %h required a5", mem[8'h12]);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL write_idle: busy=%b done=%b required 0", busy, done);
    end
  endtask

  task automatic test_busy_ignore();
    int b = wadr.size();
    int d0 = done_cnt;
    bit seen = 1'b0;
    lat = 0;
    @(negedge clk);
    cmd_rd = 1'b0; cmd_dev = 7'h50; cmd_reg = 8'h12; cmd_wdata = 8'h3C;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_high: got %b required 1", busy);
    end
    cmd_reg = 8'h34; cmd_wdata = 8'h77; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    cmd_reg = 8'h12; cmd_wdata = 8'h55; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL busy_done: no done within bound");
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL busy_done_count: got %0d required 1", done_cnt - d0);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_after: got %b required 0", busy);
    end
    checks++;
    if (wadr.size() - b != 6) begin
      failures++;
      $display("FAIL busy_writes: got %0d required 6", wadr.size() - b);
    end
    checks++;
    if (mem[8'h12] !== 8'h3C) begin
      failures++;
      $display("FAIL busy_slave: got %h required 3c", mem[8'h12]);
    end
  endtask

  task automatic test_read();
    logic [15:0] e [7] = '{16'h03A0, 16'h0490, 16'h0312, 16'h0410,
                           16'h03A1, 16'h0490, 16'h0468};
    int b = wadr.size();
    int r0 = rx_reads;
    bit ok;
    lat = 2;
    do_cmd(1'b1, 7'h50, 8'h12, 8'h00, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL read_done: no done within bound");
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL read_err: got %b required 0", err);
    end
    checks++;
    if (rdata !== 8'h3C) begin
      failures++;
      $display("FAIL read_data: got %h required 3c", rdata);
    end
    checks++;
    if (wadr.size() - b != 7) begin
      failures++;
      $display("FAIL read_count: got %0d required 7", wadr.size() - b);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (wadr.size() <= b + i || wadr[b+i] !== BASE + {24'd0, e[i][15:8]} ||
          wdat[b+i] !== {24'd0, e[i][7:0]}) begin
        failures++;
        $display("FAIL read_seq[%0d]: got adr=%h dat=%h required off=%h byte=%h",
                 i, wadr[b+i], wdat[b+i], e[i][15:8], e[i][7:0]);
      end
    end
    checks++;
    if (rx_reads - r0 != 1) begin
      failures++;
      $display("FAIL read_rxr: got %0d reads required 1", rx_reads - r0);
    end
  endtask

  task automatic test_nack();
    logic [15:0] e [3] = '{16'h0344, 16'h0490, 16'h0440};
    int b = wadr.size();
    bit ok;
    lat = 0;
    do_cmd(1'b0, 7'h22, 8'h12, 8'h99, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL nack_done: no done within bound");
    end
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL nack_err: got %b required 1", err);
    end
    checks++;
    if (rdata !== 8'h3C) begin
      failures++;
      $display("FAIL nack_rdata: got %h required 3c", rdata);
    end
    checks++;
    if (wadr.size() - b != 3) begin
      failures++;
      $display("FAIL nack_count: got %0d required 3", wadr.size() - b);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wadr.size() <= b + i || wadr[b+i] !== BASE + {24'd0, e[i][15:8]} ||
          wdat[b+i] !== {24'd0, e[i][7:0]}) begin
        failures++;
        $display("FAIL nack_seq[%0d]: got adr=%h dat=%h required off=%h byte=%h",
                 i, wadr[b+i], wdat[b+i], e[i][15:8], e[i][7:0]);
      end
    end
  endtask

  task automatic test_arb_lost();
    int b = wadr.size();
    bit ok;
    force_al = 1'b1;
    do_cmd(1'b0, 7'h50, 8'h12, 8'h11, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL al_done: no done within bound");
    end
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL al_err: got %b required 1", err);
    end
    checks++;
    if (wadr.size() - b != 2) begin
      failures++;
      $display("FAIL al_count: got %0d required 2 (no STO)", wadr.size() - b);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL al_busy: got %b required 0", busy);
    end
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL al_err_hold: got %b required 1", err);
    end
    force_al = 1'b0;
  endtask

  task automatic test_timeout();
    int b = wadr.size();
    int s0 = sr_reads;
    bit ok;
    stuck_tip = 1'b1;
    do_cmd(1'b0, 7'h50, 8'h12, 8'h22, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL tmo_done: no done within bound");
    end
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_err: got %b required 1", err);
    end
    checks++;
    if (sr_reads - s0 != 4) begin
      failures++;
      $display("FAIL tmo_polls: got %0d required 4", sr_reads - s0);
    end
    checks++;
    if (wadr.size() - b != 2) begin
      failures++;
      $display("FAIL tmo_count: got %0d required 2", wadr.size() - b);
    end
    stuck_tip = 1'b0;
  endtask

  task automatic test_reset_mid();
    int b;
    bit hit = 1'b0;
    bit ok;
    lat = 0;
    stall_at = wadr.size() + 2;
    @(negedge clk);
    cmd_rd = 1'b0; cmd_dev = 7'h50; cmd_reg = 8'h12; cmd_wdata = 8'h00;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (m_cyc_o && m_we_o && m_adr_o == BASE + 3 && m_dat_o == 32'h12) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (!hit || m_cyc_o !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_stall: hit=%b cyc=%b busy=%b required 1", hit, m_cyc_o, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_abort: cyc=%b stb=%b busy=%b required 0", m_cyc_o, m_stb_o, busy);
    end
    repeat (3) @(negedge clk);
    stall_at = -1;
    rst = 1'b1;
    b = wadr.size();
    do_cmd(1'b0, 7'h50, 8'h12, 8'h5A, ok);
    checks++;
    if (!ok || err !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_redo: ok=%b err=%b required 1/0", ok, err);
    end
    checks++;
    if (wadr.size() - b != 9 || wadr[b] !== BASE || wdat[b] !== 32'h63) begin
      failures++;
      $display("FAIL rstmid_init: count=%0d first adr=%h dat=%h required 9/%h/63",
               wadr.size() - b, wadr[b], wdat[b], BASE);
    end
    checks++;
    if (mem[8'h12] !== 8'h5A) begin
      failures++;
      $display("FAIL rstmid_slave: got %h required 5a", mem[8'h12]);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_busy_ignore();
    test_read();
    test_nack();
    test_arb_lost();
    test_timeout();
    test_reset_mid();
    checks++;
    if (bad_bus != 0) begin
      failures++;
      $display("FAIL bus_sel_stb: got %0d bad cycles required 0", bad_bus);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
